// File: rtl/rv32i_types.sv
// Shared RV32I core types.
// Purpose : constants and the CDB broadcast record used by the CDB arbiter
//           and by its consumers (reservation stations, ROB, regfile).
// Ports   : none (package).
package rv32i_types;

  localparam int NUM_FU        = 4;
  localparam int CDB_ROB_DEPTH = 32;
  localparam int CDB_TAG_W     = $clog2(CDB_ROB_DEPTH);

  typedef struct packed {
    logic                 valid;
    logic [CDB_TAG_W-1:0] tag;
    logic [4:0]           rd;
    logic [31:0]          data;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus interface.
// Purpose : groups the requester handshake and the CDB broadcast signals.
// Signals : req_valid/req_tag/req_rd/req_data (FU -> arbiter),
//           req_ready (arbiter -> FU, one-hot),
//           cdb_stall (consumer -> arbiter),
//           cdb_valid/cdb_tag/cdb_rd/cdb_data/cdb_src (arbiter -> consumers).
// Modports: slave = arbiter side, master = functional units / consumer side.
interface cdb_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 5,
  parameter int SRC_W   = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0][4:0]       req_rd;
  logic [NUM_REQ-1:0][31:0]      req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          cdb_stall;
  logic                          cdb_valid;
  logic [TAG_W-1:0]              cdb_tag;
  logic [4:0]                    cdb_rd;
  logic [31:0]                   cdb_data;
  logic [SRC_W-1:0]              cdb_src;

  modport slave (
    input  req_valid, req_tag, req_rd, req_data, cdb_stall,
    output req_ready, cdb_valid, cdb_tag, cdb_rd, cdb_data, cdb_src
  );

  modport master (
    output req_valid, req_tag, req_rd, req_data, cdb_stall,
    input  req_ready, cdb_valid, cdb_tag, cdb_rd, cdb_data, cdb_src
  );

endinterface

// File: rtl/cdb_arbiter_rr.sv
// Round-robin priority selector (purely combinational).
// Purpose : picks the first asserted request at or after ptr, wrapping.
// Ports   : req       - request vector
//           ptr       - index with highest priority this cycle
//           grant     - one-hot winner (all zero when nothing requests)
//           grant_idx - binary index of the winner
//           any_grant - at least one request is asserted
module rr_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_REQ = NUM_FU,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             hi_hit;
  logic             lo_hit;

  // Two priority searches: the lowest request at or above ptr wins; if none
  // exists the search wraps and the lowest request overall wins. Scanning
  // downward lets the last match be the lowest index.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_idx = IDX_W'(j);
        lo_hit = 1'b1;
        if (j >= int'(ptr)) begin
          hi_idx = IDX_W'(j);
          hi_hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant            = '0;
    grant_idx        = hi_hit ? hi_idx : lo_idx;
    any_grant        = lo_hit;
    grant[grant_idx] = lo_hit;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter.
// Purpose : grants one completed FU result per cycle, round-robin, and
//           registers it onto the CDB. Honours consumer backpressure and
//           drops the registered broadcast on a branch flush.
// Ports   : clk   - clock, all state on the rising edge
//           rst_n - asynchronous active-low reset
//           flush - branch mispredicted; kills the registered broadcast
//           bus   - cdb_arbiter_if.slave (requester handshake + CDB outputs)
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_REQ   = NUM_FU,
  parameter int ROB_DEPTH = CDB_ROB_DEPTH,
  parameter int TAG_W     = $clog2(ROB_DEPTH),
  parameter int SRC_W     = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  cdb_arbiter_if.slave        bus
);

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   rr_next;
  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   win_idx;
  logic               any_win;
  logic               load_en;
  logic               transfer;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SRC_W)
  ) u_rr (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (win_idx),
    .any_grant (any_win)
  );

  // The output register may be reloaded when it is empty or being consumed;
  // a flush blocks acceptance outright. rst_n gates req_ready so nothing is
  // handed off while the block is held in reset.
  always_comb begin
    load_en       = (!bus.cdb_valid || !bus.cdb_stall) && !flush;
    transfer      = load_en && any_win && rst_n;
    bus.req_ready = transfer ? grant : '0;
    rr_next       = (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
  end

  // Flush clears the broadcast ahead of stall and any transfer. Without a
  // winner a consumed broadcast drains; under stall everything holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cdb_valid <= 1'b0;
      bus.cdb_tag   <= '0;
      bus.cdb_rd    <= '0;
      bus.cdb_data  <= '0;
      bus.cdb_src   <= '0;
      rr_ptr        <= '0;
    end else if (flush) begin
      bus.cdb_valid <= 1'b0;
    end else if (load_en) begin
      if (any_win) begin
        bus.cdb_valid <= 1'b1;
        bus.cdb_tag   <= bus.req_tag[win_idx];
        bus.cdb_rd    <= bus.req_rd[win_idx];
        bus.cdb_data  <= bus.req_data[win_idx];
        bus.cdb_src   <= win_idx;
        rr_ptr        <= rr_next;
      end else begin
        bus.cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter.
// Purpose : drives hand-written requester/stall/flush sequences and checks
//           req_ready and the CDB outputs against hand-computed values.
module tb_cdb_arbiter;

  logic clk;
  logic rst_n;
  logic flush;

  int vectors;
  int miscompares;

  logic [4:0]  tagTab  [4];
  logic [4:0]  rdTab   [4];
  logic [31:0] dataTab [4];

  logic [3:0] starveValid [5];
  logic [3:0] starveReady [5];
  logic [1:0] starveSrc   [5];

  cdb_arbiter_if #(.NUM_REQ(4), .TAG_W(5), .SRC_W(2)) bus ();

  cdb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] valid, input logic stall, input logic fl);
    for (int i = 0; i < 4; i++) begin
      bus.req_tag[i]  = tagTab[i];
      bus.req_rd[i]   = rdTab[i];
      bus.req_data[i] = dataTab[i];
    end
    bus.req_valid = valid;
    bus.cdb_stall = stall;
    flush         = fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    tagTab  = '{5'd3, 5'd7, 5'd12, 5'd20};
    rdTab   = '{5'd1, 5'd2, 5'd3, 5'd4};
    dataTab = '{32'h0000_0100, 32'h0000_0101, 32'h0000_0102, 32'h0000_0103};

    // Reset with every FU requesting: nothing accepted, CDB empty.
    rst_n = 1'b0;
    applyStimulus(4'b1111, 1'b0, 1'b0);
    #2;
    checkOutput("reset_ready", bus.req_ready, 4'b0000);
    checkOutput("reset_valid", bus.cdb_valid, 1'b0);
    checkOutput("reset_src",   bus.cdb_src,   2'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("first_ready", bus.req_ready, 4'b0001);

    // Back-to-back: all four valid, one broadcast per cycle in rotation.
    begin
      logic [3:0] expReady [5];
      logic [4:0] expTag   [5];
      expReady = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      expTag   = '{5'd3, 5'd7, 5'd12, 5'd20, 5'd3};
      for (int k = 0; k < 5; k++) begin
        checkOutput("b2b_ready", bus.req_ready, expReady[k]);
        tick();
        checkOutput("b2b_valid", bus.cdb_valid, 1'b1);
        checkOutput("b2b_tag",   bus.cdb_tag,   expTag[k]);
        checkOutput("b2b_data",  bus.cdb_data,  dataTab[k % 4]);
        #1;
      end
    end

    // Asynchronous reset in the middle of a broadcast clears outputs at once.
    rst_n = 1'b0;
    #1;
    checkOutput("areset_valid", bus.cdb_valid, 1'b0);
    checkOutput("areset_tag",   bus.cdb_tag,   5'd0);
    checkOutput("areset_data",  bus.cdb_data,  32'd0);
    checkOutput("areset_ready", bus.req_ready, 4'b0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_ready", bus.req_ready, 4'b0001);
    tick();
    checkOutput("post_reset_tag", bus.cdb_tag, 5'd3);
    checkOutput("post_reset_src", bus.cdb_src, 2'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("drain1_valid", bus.cdb_valid, 1'b0);

    // Stall hold: FU2 broadcasts, consumer stalls three cycles, FU1 waits.
    tagTab[2]  = 5'd5;
    rdTab[2]   = 5'd9;
    dataTab[2] = 32'hDEAD_BEEF;
    applyStimulus(4'b0100, 1'b0, 1'b0);
    #1;
    checkOutput("stall_pre_ready", bus.req_ready, 4'b0100);
    tick();
    checkOutput("stall_tag0",  bus.cdb_tag,  5'd5);
    checkOutput("stall_data0", bus.cdb_data, 32'hDEAD_BEEF);
    checkOutput("stall_src0",  bus.cdb_src,  2'd2);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    #1;
    checkOutput("stall_ready0", bus.req_ready, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("stall_hold_tag",   bus.cdb_tag,   5'd5);
      checkOutput("stall_hold_valid", bus.cdb_valid, 1'b1);
      checkOutput("stall_hold_ready", bus.req_ready, 4'b0000);
    end
    tick();
    applyStimulus(4'b0010, 1'b0, 1'b0);
    #1;
    checkOutput("stall_last_data",  bus.cdb_data,  32'hDEAD_BEEF);
    checkOutput("stall_release_ready", bus.req_ready, 4'b0010);
    tick();
    checkOutput("after_stall_tag", bus.cdb_tag, 5'd7);
    checkOutput("after_stall_src", bus.cdb_src, 2'd1);

    // Flush with a stalled broadcast and FU0 waiting: flush wins.
    applyStimulus(4'b0001, 1'b1, 1'b1);
    #1;
    checkOutput("flush_ready",     bus.req_ready, 4'b0000);
    checkOutput("flush_pre_valid", bus.cdb_valid, 1'b1);
    tick();
    checkOutput("flush_valid", bus.cdb_valid, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    #1;
    checkOutput("post_flush_ready", bus.req_ready, 4'b0001);
    tick();
    checkOutput("post_flush_src", bus.cdb_src, 2'd0);
    checkOutput("post_flush_tag", bus.cdb_tag, 5'd3);

    // Starvation: FU0/FU3 always valid, FU1/FU2 alternate; FU3 wins on the third.
    tagTab[2]  = 5'd12;
    rdTab[2]   = 5'd3;
    dataTab[2] = 32'h0000_0102;
    starveValid = '{4'b1011, 4'b1101, 4'b1011, 4'b1011, 4'b1011};
    starveReady = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    starveSrc   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int k = 0; k < 5; k++) begin
      applyStimulus(starveValid[k], 1'b0, 1'b0);
      #1;
      checkOutput("starve_ready", bus.req_ready, starveReady[k]);
      tick();
      checkOutput("starve_src", bus.cdb_src, starveSrc[k]);
    end

    // Idle drain: single FU1 transfer with rd=0, broadcast lasts one cycle.
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("idle_valid", bus.cdb_valid, 1'b0);
    rdTab[1] = 5'd0;
    applyStimulus(4'b0010, 1'b0, 1'b0);
    #1;
    checkOutput("single_ready", bus.req_ready, 4'b0010);
    tick();
    checkOutput("single_valid", bus.cdb_valid, 1'b1);
    checkOutput("single_src",   bus.cdb_src,   2'd1);
    checkOutput("single_rd",    bus.cdb_rd,    5'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("single_drain", bus.cdb_valid, 1'b0);
    tick();
    checkOutput("single_stays_idle", bus.cdb_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
